pwm_stage: RTL and testbench

PWM_STAGE -- requirements
Module: pwm_stage

---
 rtl/pwm_stage.sv | 114 +++++++++++
 tb/tb_pwm_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_stage.sv
// PWM compare stage: detects wraps of an upstream 8-bit counter, double-buffers the
// duty value so it only changes on a period boundary, and flags illegal count steps.
module pwm_stage #(
  parameter bit INC_DEC = 1'b1,
  parameter bit POL     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cnt,
  input  logic [7:0]  cmp_data,
  input  logic        cmp_valid,
  output logic        cmp_ready,
  output logic        pwm,
  output logic        period_pulse,
  output logic [15:0] period_cnt,
  output logic        step_err
);

  localparam int unsigned CW = 8;
  localparam int unsigned PW = 16;

  localparam logic [CW-1:0] WRAP_FROM = INC_DEC ? CW'(8'hFF) : CW'(8'h00);
  localparam logic [CW-1:0] WRAP_TO   = INC_DEC ? CW'(8'h00) : CW'(8'hFF);
  localparam logic [PW-1:0] PCNT_MAX  = '1;

  // registered state
  logic [CW-1:0] prev_cnt;
  logic          prev_vld;
  logic [CW-1:0] pend_val;
  logic          pend_flag;
  logic [CW-1:0] active_cmp;

  // next-state values
  logic [CW-1:0] pend_val_nxt;
  logic          pend_flag_nxt;
  logic [CW-1:0] active_cmp_nxt;
  logic          pwm_nxt;
  logic          period_pulse_nxt;
  logic [PW-1:0] period_cnt_nxt;
  logic          step_err_nxt;

  // combinational helpers
  logic          wrap_c;
  logic          xfer_c;
  logic          apply_c;
  logic [CW-1:0] step_exp_c;
  logic [CW-1:0] eff_cmp_c;

  assign cmp_ready = !pend_flag;

  // Wrap / step decode and compare selection; a pending value applied on the wrap
  // cycle already drives the compare for that same cycle.
  always_comb begin
    wrap_c     = prev_vld && (prev_cnt == WRAP_FROM) && (cnt == WRAP_TO);
    step_exp_c = INC_DEC ? (prev_cnt + CW'(1)) : (prev_cnt - CW'(1));
    xfer_c     = cmp_valid && !pend_flag;
    apply_c    = wrap_c && pend_flag;
    eff_cmp_c  = apply_c ? pend_val : active_cmp;
  end

  // Next-state logic; xfer_c and apply_c are exclusive since xfer needs an empty buffer.
  always_comb begin
    pend_val_nxt     = pend_val;
    pend_flag_nxt    = pend_flag;
    active_cmp_nxt   = active_cmp;
    pwm_nxt          = (cnt < eff_cmp_c) ^ POL;
    period_pulse_nxt = wrap_c;
    period_cnt_nxt   = period_cnt;
    step_err_nxt     = step_err;

    if (apply_c) begin
      active_cmp_nxt = pend_val;
      pend_flag_nxt  = 1'b0;
    end

    if (xfer_c) begin
      pend_val_nxt  = cmp_data;
      pend_flag_nxt = 1'b1;
    end

    if (wrap_c && (period_cnt != PCNT_MAX)) begin
      period_cnt_nxt = period_cnt + PW'(1);
    end

    if (prev_vld && !wrap_c && (cnt != step_exp_c)) begin
      step_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cnt     <= '0;
      prev_vld     <= 1'b0;
      pend_val     <= '0;
      pend_flag    <= 1'b0;
      active_cmp   <= '0;
      pwm          <= POL;
      period_pulse <= 1'b0;
      period_cnt   <= '0;
      step_err     <= 1'b0;
    end else begin
      prev_cnt     <= cnt;
      prev_vld     <= 1'b1;
      pend_val     <= pend_val_nxt;
      pend_flag    <= pend_flag_nxt;
      active_cmp   <= active_cmp_nxt;
      pwm          <= pwm_nxt;
      period_pulse <= period_pulse_nxt;
      period_cnt   <= period_cnt_nxt;
      step_err     <= step_err_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_stage.sv
// Directed bench for pwm_stage: an up-counting active-high instance and a
// down-counting active-low instance fed with the complementary count.
module tb_pwm_stage;

  logic        clk;
  logic        rst_n;
  logic [7:0]  cnt;
  logic [7:0]  cmp_data;
  logic        cmp_valid;
  logic        cmp_ready;
  logic        pwm;
  logic        period_pulse;
  logic [15:0] period_cnt;
  logic        step_err;

  logic [7:0]  cnt_b;
  logic [7:0]  cmp_data_b;
  logic        cmp_valid_b;
  logic        cmp_ready_b;
  logic        pwm_b;
  logic        period_pulse_b;
  logic [15:0] period_cnt_b;
  logic        step_err_b;

  int          n_checks;
  int          n_errors;
  int          acc_ones;
  int          acc_ones_b;
  int          acc_pulse;
  int          exp_pc;
  logic [7:0]  cur;

  pwm_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt          (cnt),
    .cmp_data     (cmp_data),
    .cmp_valid    (cmp_valid),
    .cmp_ready    (cmp_ready),
    .pwm          (pwm),
    .period_pulse (period_pulse),
    .period_cnt   (period_cnt),
    .step_err     (step_err)
  );

  pwm_stage #(.INC_DEC(1'b0), .POL(1'b1)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt          (cnt_b),
    .cmp_data     (cmp_data_b),
    .cmp_valid    (cmp_valid_b),
    .cmp_ready    (cmp_ready_b),
    .pwm          (pwm_b),
    .period_pulse (period_pulse_b),
    .period_cnt   (period_cnt_b),
    .step_err     (step_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    acc_ones   = 0;
    acc_ones_b = 0;
    acc_pulse  = 0;
  endtask

  // advance the legal count by n steps, accumulating observed outputs
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      cur   = cur + 8'd1;
      cnt   = cur;
      cnt_b = ~cur;
      tick();
      acc_ones   += int'(pwm);
      acc_ones_b += int'(pwm_b);
      acc_pulse  += int'(period_pulse);
    end
  endtask

  task automatic setcnt(input logic [7:0] v);
    cur   = v;
    cnt   = v;
    cnt_b = ~v;
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    cur         = 8'd0;
    cnt         = 8'd0;
    cnt_b       = 8'hFF;
    cmp_data    = 8'd0;
    cmp_valid   = 1'b0;
    cmp_data_b  = 8'd0;
    cmp_valid_b = 1'b0;
    clr();
    tick();
    tick();

    // reset state
    check("rst_pwm",     32'(pwm), 32'd0);
    check("rst_pulse",   32'(period_pulse), 32'd0);
    check("rst_pcnt",    32'(period_cnt), 32'd0);
    check("rst_steperr", 32'(step_err), 32'd0);
    check("rst_ready",   32'(cmp_ready), 32'd1);
    check("rst_pwm_b",   32'(pwm_b), 32'd1);
    check("rst_ready_b", 32'(cmp_ready_b), 32'd1);

    // release; down counter sees prev 00 -> FF here, which must not count as a wrap
    rst_n = 1'b1;
    tick();
    check("rel_pulse_b", 32'(period_pulse_b), 32'd0);
    check("rel_step_b",  32'(step_err_b), 32'd0);
    check("rel_pulse",   32'(period_pulse), 32'd0);

    // load 64 / 200 in the first period
    clr();
    adv(5);
    cmp_valid = 1'b1; cmp_data = 8'd64; cmp_valid_b = 1'b1; cmp_data_b = 8'd200;
    adv(1);
    cmp_valid = 1'b0; cmp_data = 8'hAA; cmp_valid_b = 1'b0;
    check("ld_ready",   32'(cmp_ready), 32'd0);
    check("ld_ready_b", 32'(cmp_ready_b), 32'd0);
    adv(249);
    check("p1_ones",   32'(acc_ones), 32'd0);
    check("p1_ones_b", 32'(acc_ones_b), 32'd255);
    check("p1_pulses", 32'(acc_pulse), 32'd0);
    adv(1);
    check("w1_pwm",   32'(pwm), 32'd1);
    check("w1_pulse", 32'(period_pulse), 32'd1);
    check("w1_pcnt",  32'(period_cnt), 32'd1);
    check("w1_ready", 32'(cmp_ready), 32'd1);
    check("w1_pwm_b", 32'(pwm_b), 32'd1);
    clr();
    adv(63);
    check("d64_at63", 32'(pwm), 32'd1);
    adv(1);
    check("d64_at64", 32'(pwm), 32'd0);
    adv(192);
    check("d64_ones",   32'(acc_ones), 32'd64);
    check("d64_pulses", 32'(acc_pulse), 32'd1);
    check("d64_pcnt",   32'(period_cnt), 32'd2);
    check("d200_ones_b", 32'(acc_ones_b), 32'd56);

    // back-to-back beats 10 then 20
    cmp_valid = 1'b1; cmp_data = 8'd10;
    adv(1);
    cmp_data = 8'd20;
    adv(1);
    check("bb_ready_mid", 32'(cmp_ready), 32'd0);
    adv(253);
    check("bb_ready_end", 32'(cmp_ready), 32'd0);
    adv(1);
    check("bb_wrap_pwm",   32'(pwm), 32'd1);
    check("bb_wrap_ready", 32'(cmp_ready), 32'd1);
    check("bb_wrap_pcnt",  32'(period_cnt), 32'd3);
    clr();
    adv(1);
    cmp_valid = 1'b0;
    check("bb_second_ready", 32'(cmp_ready), 32'd0);
    adv(255);
    check("bb_ones10", 32'(acc_ones), 32'd10);
    check("bb_pcnt4",  32'(period_cnt), 32'd4);
    clr();
    adv(255);
    check("bb_ones20", 32'(acc_ones), 32'd19);
    check("bb_at255",  32'(pwm), 32'd0);

    // transfer on the wrap cycle only fills the buffer; then duty 0 and 255
    cmp_valid = 1'b1; cmp_data = 8'd0;
    adv(1);
    cmp_valid = 1'b0;
    check("wfill_pwm",   32'(pwm), 32'd1);
    check("wfill_ready", 32'(cmp_ready), 32'd0);
    check("wfill_pcnt",  32'(period_cnt), 32'd5);
    clr();
    adv(255);
    check("wfill_ones", 32'(acc_ones), 32'd19);
    adv(1);
    check("c0_wrap_pwm", 32'(pwm), 32'd0);
    check("c0_pcnt",     32'(period_cnt), 32'd6);
    clr();
    cmp_valid = 1'b1; cmp_data = 8'd255;
    adv(1);
    cmp_valid = 1'b0;
    adv(254);
    check("c0_ones", 32'(acc_ones), 32'd0);
    clr();
    adv(256);
    check("c255_ones", 32'(acc_ones), 32'd255);
    check("c255_last", 32'(pwm), 32'd0);
    check("c255_pcnt", 32'(period_cnt), 32'd7);

    // step error: wrap is legal, 10 -> 12 is not
    adv(1);
    check("wrap_no_err",   32'(step_err), 32'd0);
    check("wrap_no_err_b", 32'(step_err_b), 32'd0);
    adv(16);
    check("pre_jump_err", 32'(step_err), 32'd0);
    setcnt(8'h12);
    check("jump_err",   32'(step_err), 32'd1);
    check("jump_err_b", 32'(step_err_b), 32'd1);
    adv(5);
    check("err_sticky", 32'(step_err), 32'd1);

    // fast two-cycle wraps: period_cnt follows each pulse
    exp_pc = 8;
    for (int i = 0; i < 290; i++) begin
      setcnt(8'hFF);
      check("fw_nopulse", 32'(period_pulse), 32'd0);
      setcnt(8'h00);
      exp_pc++;
      check("fw_pulse", 32'(period_pulse), 32'd1);
      check("fw_pcnt",  32'(period_cnt), 32'(exp_pc));
    end

    // preset near saturation across a non-wrap edge, then wrap past the top
    force dut.period_cnt = 16'hFFFC;
    setcnt(8'h55);
    release dut.period_cnt;
    check("sat_preset", 32'(period_cnt), 32'h0000FFFC);
    exp_pc = 32'h0000FFFC;
    for (int i = 0; i < 6; i++) begin
      setcnt(8'hFF);
      setcnt(8'h00);
      if (exp_pc < 32'h0000FFFF) exp_pc++;
      check("sat_pcnt", 32'(period_cnt), 32'(exp_pc));
    end

    // reset mid-period with a pending compare value
    setcnt(8'hFF);
    cmp_valid = 1'b1; cmp_data = 8'd77;
    setcnt(8'h00);
    cmp_valid = 1'b0;
    check("pre_rst_pulse", 32'(period_pulse), 32'd1);
    check("pre_rst_ready", 32'(cmp_ready), 32'd0);
    check("pre_rst_pwm",   32'(pwm), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_pwm",     32'(pwm), 32'd0);
    check("arst_pulse",   32'(period_pulse), 32'd0);
    check("arst_pcnt",    32'(period_cnt), 32'd0);
    check("arst_steperr", 32'(step_err), 32'd0);
    check("arst_ready",   32'(cmp_ready), 32'd1);
    check("arst_pwm_b",   32'(pwm_b), 32'd1);
    check("arst_step_b",  32'(step_err_b), 32'd0);
    check("arst_pcnt_b",  32'(period_cnt_b), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    setcnt(8'h00);
    check("rel2_pulse",   32'(period_pulse), 32'd0);
    check("rel2_pulse_b", 32'(period_pulse_b), 32'd0);
    check("rel2_ready",   32'(cmp_ready), 32'd1);
    check("rel2_pwm",     32'(pwm), 32'd0);
    clr();
    adv(256);
    check("rel2_wrap_pulse", 32'(period_pulse), 32'd1);
    check("rel2_pcnt",       32'(period_cnt), 32'd1);
    check("rel2_discard",    32'(acc_ones), 32'd0);
    check("rel2_steperr",    32'(step_err), 32'd0);
    check("rel2_step_b",     32'(step_err_b), 32'd0);
    check("rel2_pcnt_b",     32'(period_cnt_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
